// File: rtl/rx_packet_parser.sv
// rtl/rx_packet_parser.sv - frames transceiver words into checksummed packets and returns ACK/NACK
module rx_packet_parser #(
    parameter int unsigned TIMEOUT = 50000,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [15:0] word_in,
    input  logic        word_in_valid,
    output logic [15:0] tx_word,
    output logic        tx_word_valid,
    output logic        pkt_valid,
    output logic [3:0]  pkt_opcode,
    output logic [3:0]  pkt_len,
    input  logic [3:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [7:0]  err_count
);

    localparam int unsigned GW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CSUM
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    opcode_q, opcode_d;
    logic [3:0]    len_q, len_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   sum_q, sum_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   tx_word_q, tx_word_d;
    logic          tx_valid_q, tx_valid_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic [3:0]    pkt_opcode_q, pkt_opcode_d;
    logic [3:0]    pkt_len_q, pkt_len_d;
    logic [7:0]    err_q, err_d;
    logic [15:0]   buf_q [16];

    logic          buf_we;
    logic          err_inc;
    logic          timeout;

    // Gap only matters mid-packet; a word on the expiry edge beats the timeout.
    assign timeout = !word_in_valid && (state_q != IDLE) && (gap_q == GAP_LAST);

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        len_d        = len_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        gap_d        = gap_q;
        tx_word_d    = tx_word_q;
        tx_valid_d   = 1'b0;
        pkt_valid_d  = 1'b0;
        pkt_opcode_d = pkt_opcode_q;
        pkt_len_d    = pkt_len_q;
        buf_we       = 1'b0;
        err_inc      = 1'b0;

        if (word_in_valid) begin
            gap_d = '0;
        end else if (state_q != IDLE) begin
            gap_d = gap_q + GW'(1);
        end

        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (word_in_valid) begin
                    if (word_in[15:8] == SYNC) begin
                        opcode_d = word_in[7:4];
                        len_d    = word_in[3:0];
                        sum_d    = word_in;
                        idx_d    = 4'd0;
                        state_d  = (word_in[3:0] == 4'd0) ? CSUM : PAYLOAD;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (word_in_valid) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + word_in;
                    idx_d  = idx_q + 4'd1;
                    if (idx_q == len_q - 4'd1) begin
                        state_d = CSUM;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    err_inc = 1'b1;
                end
            end
            CSUM: begin
                if (word_in_valid) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b1;
                    if (word_in == sum_q) begin
                        pkt_valid_d  = 1'b1;
                        pkt_opcode_d = opcode_q;
                        pkt_len_d    = len_q;
                        tx_word_d    = {8'h5A, opcode_q, 4'h0};
                    end else begin
                        tx_word_d = {8'h5A, opcode_q, 4'hF};
                        err_inc   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    err_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= IDLE;
            opcode_q     <= 4'd0;
            len_q        <= 4'd0;
            idx_q        <= 4'd0;
            sum_q        <= 16'd0;
            gap_q        <= '0;
            tx_word_q    <= 16'd0;
            tx_valid_q   <= 1'b0;
            pkt_valid_q  <= 1'b0;
            pkt_opcode_q <= 4'd0;
            pkt_len_q    <= 4'd0;
            err_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            gap_q        <= gap_d;
            tx_word_q    <= tx_word_d;
            tx_valid_q   <= tx_valid_d;
            pkt_valid_q  <= pkt_valid_d;
            pkt_opcode_q <= pkt_opcode_d;
            pkt_len_q    <= pkt_len_d;
            err_q        <= err_d;
        end
    end

    // Entry 15 is never written (max 15 payload words) and always reads 0.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 16'd0;
            end
        end else if (buf_we) begin
            buf_q[idx_q] <= word_in;
        end
    end

    assign rd_data       = buf_q[rd_addr];
    assign tx_word       = tx_word_q;
    assign tx_word_valid = tx_valid_q;
    assign pkt_valid     = pkt_valid_q;
    assign pkt_opcode    = pkt_opcode_q;
    assign pkt_len       = pkt_len_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_rx_packet_parser.sv
// tb/tb_rx_packet_parser.sv - directed bench with a packet-level reference model for rx_packet_parser
module tb_rx_packet_parser;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic [15:0] word_in = 16'd0;
    logic        word_in_valid = 1'b0;
    logic [3:0]  rd_addr = 4'd0;
    logic [15:0] tx_word;
    logic        tx_word_valid;
    logic        pkt_valid;
    logic [3:0]  pkt_opcode;
    logic [3:0]  pkt_len;
    logic [15:0] rd_data;
    logic [7:0]  err_count;

    rx_packet_parser #(.TIMEOUT(TO), .SYNC(8'hA5)) dut (
        .clk           (clk),
        .rstb          (rstb),
        .word_in       (word_in),
        .word_in_valid (word_in_valid),
        .tx_word       (tx_word),
        .tx_word_valid (tx_word_valid),
        .pkt_valid     (pkt_valid),
        .pkt_opcode    (pkt_opcode),
        .pkt_len       (pkt_len),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: holds the words of the packet in flight and judges it once complete.
    logic [15:0] m_pkt[$];
    int          m_gap;
    logic [15:0] m_buf[16];
    logic [15:0] m_tx_word;
    logic        m_tx_v;
    logic        m_pv;
    logic [3:0]  m_op;
    logic [3:0]  m_len;
    int          m_err;

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_step();
        int          n;
        logic [15:0] s;
        logic [15:0] hdr;
        if (!rstb) begin
            m_pkt.delete();
            m_gap = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = 16'd0;
            m_tx_word = 16'd0;
            m_tx_v = 1'b0;
            m_pv = 1'b0;
            m_op = 4'd0;
            m_len = 4'd0;
            m_err = 0;
            return;
        end
        m_tx_v = 1'b0;
        m_pv = 1'b0;
        if (word_in_valid) begin
            m_gap = 0;
            if (m_pkt.size() == 0) begin
                if (word_in[15:8] != 8'hA5) bump_err();
                else m_pkt.push_back(word_in);
            end else begin
                m_pkt.push_back(word_in);
                hdr = m_pkt[0];
                n = int'(hdr[3:0]);
                if (m_pkt.size() <= n + 1) begin
                    m_buf[m_pkt.size() - 2] = word_in;
                end else begin
                    s = 16'd0;
                    for (int i = 0; i <= n; i++) s = s + m_pkt[i];
                    m_tx_v = 1'b1;
                    if (s == word_in) begin
                        m_pv = 1'b1;
                        m_op = hdr[7:4];
                        m_len = hdr[3:0];
                        m_tx_word = {8'h5A, hdr[7:4], 4'h0};
                    end else begin
                        m_tx_word = {8'h5A, hdr[7:4], 4'hF};
                        bump_err();
                    end
                    m_pkt.delete();
                end
            end
        end else if (m_pkt.size() > 0) begin
            m_gap++;
            if (m_gap == TO) begin
                bump_err();
                m_pkt.delete();
                m_gap = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            check("tx_word", 32'(tx_word), 32'(m_tx_word));
            check("tx_word_valid", 32'(tx_word_valid), 32'(m_tx_v));
            check("pkt_valid", 32'(pkt_valid), 32'(m_pv));
            check("pkt_opcode", 32'(pkt_opcode), 32'(m_op));
            check("pkt_len", 32'(pkt_len), 32'(m_len));
            check("err_count", 32'(err_count), 32'(m_err));
            check("rd_data", 32'(rd_data), 32'(m_buf[rd_addr]));
        end
    end

    task automatic send(input logic [15:0] w);
        word_in = w;
        word_in_valid = 1'b1;
        rd_addr = rd_addr + 4'd1;
        @(negedge clk);
        word_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0;
        idle(3);
        check("reset tx_word", 32'(tx_word), 32'h0);
        check("reset err_count", 32'(err_count), 32'h0);
        check("reset pkt_len", 32'(pkt_len), 32'h0);
        check("reset rd_data", 32'(rd_data), 32'h0);
        rstb = 1'b1;
        idle(1);

        send(16'hA512); send(16'h0001); send(16'h0002); send(16'hA515);
        check("good pkt_valid", 32'(pkt_valid), 32'h1);
        check("good opcode", 32'(pkt_opcode), 32'h1);
        check("good len", 32'(pkt_len), 32'h2);
        check("good ack", 32'(tx_word), 32'h5A10);
        check("good tx_valid", 32'(tx_word_valid), 32'h1);
        check("good err", 32'(err_count), 32'h0);
        rd_addr = 4'd0; #1;
        check("good buf0", 32'(rd_data), 32'h0001);
        rd_addr = 4'd1; #1;
        check("good buf1", 32'(rd_data), 32'h0002);
        idle(1);
        check("pulse ends", 32'(pkt_valid), 32'h0);
        check("tx_word holds", 32'(tx_word), 32'h5A10);

        send(16'hA530); send(16'hA530);
        check("zero-len ack", 32'(tx_word), 32'h5A30);
        check("zero-len len", 32'(pkt_len), 32'h0);
        check("zero-len valid", 32'(pkt_valid), 32'h1);

        send(16'hA512); send(16'h0001); send(16'h0002); send(16'h0000);
        check("bad nack", 32'(tx_word), 32'h5A1F);
        check("bad no pkt_valid", 32'(pkt_valid), 32'h0);
        check("bad err", 32'(err_count), 32'h1);
        check("bad len kept", 32'(pkt_len), 32'h0);

        send(16'hA51F);
        repeat (15) send(16'hFFFF);
        send(16'hA510);
        check("wrap ack", 32'(tx_word), 32'h5A10);
        check("wrap len", 32'(pkt_len), 32'hF);
        rd_addr = 4'd14; #1;
        check("wrap buf14", 32'(rd_data), 32'hFFFF);
        idle(1);
        send(16'hA51F);
        repeat (15) send(16'hFFFF);
        send(16'hA50F);
        check("wrap nack", 32'(tx_word), 32'h5A1F);
        check("wrap nack err", 32'(err_count), 32'h2);

        send(16'h1234);
        check("sync err", 32'(err_count), 32'h3);
        send(16'hA530); send(16'hA530);
        check("after sync ack", 32'(tx_word), 32'h5A30);

        send(16'hA512); send(16'h0001);
        idle(TO - 1);
        check("before timeout err", 32'(err_count), 32'h3);
        idle(1);
        check("timeout err", 32'(err_count), 32'h4);
        idle(2);
        check("timeout no tx", 32'(tx_word_valid), 32'h0);
        send(16'hA512); send(16'h0001); send(16'h0002); send(16'hA515);
        check("post-timeout ack", 32'(pkt_valid), 32'h1);

        send(16'hA512); send(16'h0001);
        idle(TO - 2);
        send(16'h0002); send(16'hA515);
        check("gap99 ack", 32'(pkt_valid), 32'h1);
        check("gap99 err", 32'(err_count), 32'h4);

        send(16'hA512); send(16'h0001);
        idle(TO - 1);
        send(16'h0002); send(16'hA515);
        check("edge word wins", 32'(pkt_valid), 32'h1);
        check("edge word err", 32'(err_count), 32'h4);

        send(16'hA512); send(16'h0001);
        rstb = 1'b0; #1;
        check("rst tx_word", 32'(tx_word), 32'h0);
        check("rst err", 32'(err_count), 32'h0);
        check("rst len", 32'(pkt_len), 32'h0);
        check("rst opcode", 32'(pkt_opcode), 32'h0);
        idle(2);
        rstb = 1'b1;
        idle(1);
        send(16'h0002);
        check("rst fsm idle", 32'(err_count), 32'h1);
        send(16'hA530); send(16'hA530);
        check("rst then ack", 32'(tx_word), 32'h5A30);

        repeat (260) send(16'h1234);
        check("err saturates", 32'(err_count), 32'hFF);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_packet_parser.md
# rx_packet_parser

Framing stage directly downstream of `transceiver`. It consumes the 16-bit words the transceiver emits on `data_recv`/`data_recv_valid` and assembles them into checksummed command packets. It buffers up to 15 payload words and presents each good packet to the core. For every completed packet it returns one ACK/NACK word on the transceiver's `data_send`/`data_send_valid` input.

## Interface
- `TIMEOUT`, default 50000: max clk cycles allowed between consecutive words inside a packet; must be ≥ 1.
- `SYNC`, default 8'hA5: required header sync byte.
- `clk`  in  1  system clock, all logic on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `word_in`  in  16  from transceiver `data_recv`.
- `word_in_valid`  in  1  from transceiver `data_recv_valid`; one-cycle pulse per word.
- `tx_word`  out  16  to transceiver `data_send`.
- `tx_word_valid`  out  1  to transceiver `data_send_valid`; one-cycle pulse.
- `pkt_valid`  out  1  one-cycle pulse: good packet available.
- `pkt_opcode`  out  4  opcode of last good packet.
- `pkt_len`  out  4  payload length of last good packet (0–15).
- `rd_addr`  in  4  payload buffer read index.
- `rd_data`  out  16  combinational `buf[rd_addr]`.
- `err_count`  out  8  saturating error counter.

## Operation
- Packet: header, then N payload words, then checksum word.
  - Header format: [15:8]=SYNC, [7:4]=opcode, [3:0]=N.
  - Checksum = header + all payload words, mod 2^16. Use a 16-bit adder; carries are discarded.
- FSM states: IDLE, PAYLOAD, CSUM.
- IDLE:
  - Valid word with [15:8]==SYNC: latch opcode and N; sum←word; idx←0.
    - N==0: go to CSUM.
    - Otherwise: go to PAYLOAD.
  - Valid word with [15:8]≠SYNC: dropped; err_count+1; stay in IDLE.
- PAYLOAD: each valid word does buf[idx]←word, sum←sum+word, idx←idx+1. After the word with idx==N−1 is stored, go to CSUM.
- CSUM: on a valid word, go to IDLE.
  - word==sum: pkt_valid pulse; pkt_opcode/pkt_len update; tx_word={8'h5A, opcode, 4'h0} (ACK).
  - Mismatch: tx_word={8'h5A, opcode, 4'hF} (NACK); err_count+1; pkt_opcode/pkt_len unchanged.
- Timeout:
  - Gap counter clears on every valid word and counts only in PAYLOAD/CSUM.
  - At TIMEOUT: go to IDLE, err_count+1, no tx word, no pkt_valid.
- err_count saturates at 255. Simultaneous error events in one cycle cannot occur; max one increment per cycle.
- Buffer:
  - Payload is written in place, so a new packet overwrites the previous one.
  - Contents are guaranteed stable only from pkt_valid until the next accepted header.
  - rd_addr ≥ pkt_len returns stale words, which is legal.
- word_in_valid while the response is pending cannot occur at transceiver word rates. It is nevertheless processed normally; the response register is independent of the FSM.

## Timing
- Reset values:
  - tx_word=0, tx_word_valid=0, pkt_valid=0.
  - pkt_opcode=0, pkt_len=0, err_count=0.
  - buffer all 0; FSM=IDLE; sum/idx/gap counter=0.
- Latency: pkt_valid, tx_word_valid and the new tx_word/pkt_* values are registered. They are asserted in the cycle after the clk edge that samples the checksum word's valid.
- tx_word holds its value after the pulse until the next response.
- Buffer write is visible on rd_data one cycle after the sampling edge.
- Timeout fires on the edge where the gap counter reaches TIMEOUT, i.e. TIMEOUT cycles after the last valid word; the FSM is in IDLE on the following cycle.
  - A word arriving on that exact edge wins: the counter clears and there is no timeout.
- rstb low at any time, mid-packet included: immediate return to reset values; partial packet discarded; no response.

## Test plan
- Good packet A512, 0001, 0002, A515 → one cycle after A515: pkt_valid=1, pkt_opcode=1, pkt_len=2, tx_word=5A10 with tx_word_valid=1; rd_addr 0/1 → 0001/0002; err_count=0.
- Zero-length A530, A530 → pkt_valid, pkt_len=0, tx_word=5A30. Bad checksum A512, 0001, 0002, 0000 → tx_word=5A1F, no pkt_valid, err_count=1, pkt_len still previous value.
- Wrap-around: A51F followed by 15× FFFF → checksum A51F+15·FFFF mod 2^16 = A510 accepted (ACK 5A10 path with opcode 1); checksum A50F → NACK.
- Sync error: 1234 in IDLE → err_count+1, state IDLE; then A530, A530 → ACK 5A30.
- Timeout: with TIMEOUT=100, send A512, 0001, then 100 idle cycles → IDLE, err_count+1, no tx_word_valid; a following good packet is accepted. A gap of 99 cycles → no timeout.
- Reset mid-PAYLOAD clears all outputs and the FSM; 256 sync errors → err_count holds at 255.
